// File: rtl/byte_lane_dmem.sv
// Byte-lane data memory: lane-masked stores, 1-cycle registered aligned/extended loads, clear sweep.
// Optional MEM_BYPASS_EN: a simultaneous ld+str returns the post-store merged word.
module byte_lane_dmem #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [8*DATA_BYTES-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [ADDR_BITS-1:0]    addr,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic [DATA_BYTES-1:0]   sel,
  input  logic                    str,
  input  logic                    ld,
  input  logic                    sext,
  input  logic                    wipe,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    valid,
  output logic                    busy,
  output logic                    err
);
  localparam int unsigned W = 8 * DATA_BYTES;
  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic {StSweep, StRun} state_e;

  state_e                 state;
  logic [ADDR_BITS-1:0]   cnt;
  logic [W-1:0]           mem [DEPTH];
  logic [W-1:0]           rd_word, merged, rd_next, rd_q, shifted, ld_value;
  logic [DATA_BYTES-1:0]  mask;
  logic                   legal, accept, we, ld_q, sext_q, sign;
  int                     lo, len, lo_q, len_q;

  // Legal lane patterns: aligned contiguous runs whose length is a power of two.
  always_comb begin
    legal = (sel == '0);
    lo    = 0;
    len   = 0;
    mask  = '0;
    for (int l = 1; l <= int'(DATA_BYTES); l++) begin
      for (int k = 0; k < int'(DATA_BYTES); k++) begin
        if (((l & (l - 1)) == 0) && (k % l == 0) && (k + l <= int'(DATA_BYTES))) begin
          for (int j = 0; j < int'(DATA_BYTES); j++) mask[j] = (j >= k) && (j < k + l);
          if (sel == mask) begin
            legal = 1'b1;
            lo    = k;
            len   = l;
          end
        end
      end
    end
  end

  assign accept = (state == StRun) && !wipe;
  assign we     = accept && str && legal;

  always_comb begin
    rd_word = mem[addr];
    merged  = rd_word;
    for (int j = 0; j < int'(DATA_BYTES); j++) begin
      if (sel[j]) merged[8*j +: 8] = data_in[8*j +: 8];
    end
`ifdef MEM_BYPASS_EN
    rd_next = (str && legal) ? merged : rd_word;
`else
    rd_next = rd_word;
`endif
  end

  // Array and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (state == StSweep) mem[cnt] <= INIT_VALUE;
    else if (we)          mem[addr] <= merged;
    if (accept && ld) rd_q <= rd_next;
  end

  always_comb begin
    shifted = '0;
    for (int k = 0; k < int'(DATA_BYTES); k++) begin
      if (k == lo_q) shifted = rd_q >> (8 * k);
    end
    sign = 1'b0;
    for (int b = 0; b < int'(W); b++) begin
      if (b == 8 * len_q - 1) sign = shifted[b];
    end
    ld_value = '0;
    for (int b = 0; b < int'(W); b++) begin
      if (b < 8 * len_q)   ld_value[b] = shifted[b];
      else if (len_q != 0) ld_value[b] = sext_q & sign;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= StSweep;
      cnt      <= '0;
      busy     <= 1'b1;
      data_out <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      ld_q     <= 1'b0;
      sext_q   <= 1'b0;
      lo_q     <= 0;
      len_q    <= 0;
    end else begin
      valid <= ld_q;
      err   <= 1'b0;
      ld_q  <= 1'b0;
      if (ld_q) data_out <= ld_value;
      case (state)
        StSweep: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= StRun;
            busy  <= 1'b0;
          end
        end
        StRun: begin
          if (wipe) begin
            state <= StSweep;
            cnt   <= '0;
            busy  <= 1'b1;
          end else if (ld || str) begin
            if (!legal) begin
              err <= 1'b1;
            end else if (ld) begin
              ld_q   <= 1'b1;
              lo_q   <= lo;
              len_q  <= len;
              sext_q <= sext;
            end
          end
        end
        default: state <= StSweep;
      endcase
    end
  end
endmodule

// File: tb/tb_byte_lane_dmem.sv
// Scoreboard bench for byte_lane_dmem: directed requests push expectations, a monitor pops them.
module tb_byte_lane_dmem;
  logic        clk = 1'b0;
  logic        clr, str, ld, sext, wipe;
  logic [9:0]  addr;
  logic [31:0] data_in, data_out;
  logic [3:0]  sel;
  logic        valid, busy, err;

  typedef struct {
    logic        v;
    logic        e;
    logic [31:0] d;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_d = 32'h0;

  byte_lane_dmem dut (
    .clk(clk), .clr(clr), .addr(addr), .data_in(data_in), .sel(sel), .str(str), .ld(ld),
    .sext(sext), .wipe(wipe), .data_out(data_out), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid || err) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: valid=%b err=%b data_out=%h, required no output",
                 valid, err, data_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (valid !== e.v || err !== e.e || data_out !== e.d) begin
          errors++;
          $display("FAIL %s: valid=%b err=%b data_out=%h, required valid=%b err=%b data_out=%h",
                   e.name, valid, err, data_out, e.v, e.e, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld = 0; str = 0; wipe = 0; sel = 4'h0; sext = 0; data_in = 32'h0;
  endtask

  task automatic push_ld(input string name, input logic [31:0] d);
    exp_t e;
    e.v = 1'b1; e.e = 1'b0; e.d = d; e.name = name;
    q.push_back(e);
    last_d = d;
  endtask

  task automatic push_err(input string name);
    exp_t e;
    e.v = 1'b0; e.e = 1'b1; e.d = last_d; e.name = name;
    q.push_back(e);
  endtask

  task automatic req(input logic l, input logic s, input logic [3:0] sl, input logic [9:0] a,
                     input logic [31:0] d, input logic sx);
    ld = l; str = s; sel = sl; addr = a; data_in = d; sext = sx;
    cyc();
    idle();
    cyc();
    cyc();
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      cyc();
      n++;
    end
    chk(name, n, 1024);
  endtask

  initial begin
    idle();
    addr = 10'd0;
    clr  = 1'b1;
    cyc();
    cyc();
    chk("reset_busy", 32'(busy), 1);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_data_out", data_out, 32'h0);
    clr = 1'b0;
    count_busy("sweep_length");

    push_ld("ld_after_sweep", 32'h0000_0000);
    req(1, 0, 4'b1111, 10'd5, 32'h0, 0);

    req(0, 1, 4'b0100, 10'd3, 32'h00A5_0000, 0);
    push_ld("ld_byte_sext", 32'hFFFF_FFA5);
    req(1, 0, 4'b0100, 10'd3, 32'h0, 1);
    push_ld("ld_byte_zext", 32'h0000_00A5);
    req(1, 0, 4'b0100, 10'd3, 32'h0, 0);
    push_ld("ld_byte_lane0", 32'h0000_0000);
    req(1, 0, 4'b0001, 10'd3, 32'h0, 1);
    push_ld("ld_word_after_byte", 32'h00A5_0000);
    req(1, 0, 4'b1111, 10'd3, 32'h0, 0);

    req(0, 1, 4'b1100, 10'd3, 32'h8012_0000, 0);
    push_ld("ld_half_sext", 32'hFFFF_8012);
    req(1, 0, 4'b1100, 10'd3, 32'h0, 1);
    push_ld("ld_word_after_half", 32'h8012_0000);
    req(1, 0, 4'b1111, 10'd3, 32'h0, 1);
    push_ld("ld_byte1_sext", 32'h0000_0000);
    req(1, 0, 4'b0010, 10'd3, 32'h0, 1);

    push_err("str_illegal_0110");
    req(0, 1, 4'b0110, 10'd3, 32'hFFFF_FFFF, 0);
    push_ld("word_unchanged", 32'h8012_0000);
    req(1, 0, 4'b1111, 10'd3, 32'h0, 0);
    push_err("ld_illegal_0111");
    req(1, 0, 4'b0111, 10'd3, 32'h0, 1);
    push_err("ld_illegal_1010");
    req(1, 0, 4'b1010, 10'd3, 32'h0, 0);

    req(0, 1, 4'b1111, 10'd7, 32'h1122_3344, 0);
`ifdef MEM_BYPASS_EN
    push_ld("ld_str_same_cycle", 32'hAABB_CCDD);
`else
    push_ld("ld_str_same_cycle", 32'h1122_3344);
`endif
    req(1, 1, 4'b1111, 10'd7, 32'hAABB_CCDD, 0);
    push_ld("ld_after_ld_str", 32'hAABB_CCDD);
    req(1, 0, 4'b1111, 10'd7, 32'h0, 0);
    push_ld("ld_byte3_sext", 32'hFFFF_FFAA);
    req(1, 0, 4'b1000, 10'd7, 32'h0, 1);
    push_ld("ld_half0_zext", 32'h0000_CCDD);
    req(1, 0, 4'b0011, 10'd7, 32'h0, 0);
    push_ld("ld_sel_zero", 32'h0000_0000);
    req(1, 0, 4'b0000, 10'd7, 32'h0, 1);

    // wipe on the same edge as a store: the store is dropped
    wipe = 1; str = 1; sel = 4'b1111; addr = 10'd9; data_in = 32'h1234_5678;
    cyc();
    idle();
    chk("wipe_sets_busy", 32'(busy), 1);
    count_busy("wipe_sweep_length");
    push_ld("ld_addr9_after_wipe", 32'h0000_0000);
    req(1, 0, 4'b1111, 10'd9, 32'h0, 0);
    push_ld("ld_addr7_after_wipe", 32'h0000_0000);
    req(1, 0, 4'b1111, 10'd7, 32'h0, 0);
    push_ld("ld_addr3_after_wipe", 32'h0000_0000);
    req(1, 0, 4'b1111, 10'd3, 32'h0, 0);

    // loads held during a sweep must be ignored; clr at count 500 restarts it
    wipe = 1;
    cyc();
    wipe = 0; ld = 1; sel = 4'b1111; addr = 10'd1;
    repeat (500) cyc();
    idle();
    clr = 1'b1;
    #1;
    chk("clr_mid_sweep_busy", 32'(busy), 1);
    cyc();
    cyc();
    clr = 1'b0;
    count_busy("restart_sweep_length");
    push_ld("ld_after_restart", 32'h0000_0000);
    req(1, 0, 4'b1111, 10'd1, 32'h0, 0);

    repeat (3) cyc();
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
